fpgasynth_key_ctrl: RTL and testbench

Memory-mapped pushbutton controller for the synth front panel. It sits on the Avalon-MM bus between the raw board keys and the Nios control software. For each key it synchronises and debounces the input, captures press events in a sticky register, and raises a maskable interrupt. Software reads clean key state and press events instead of polling and filtering bouncing pins.

---
 rtl/fpgasynth_key_pkg.sv | 17 +
 rtl/fpgasynth_key_debounce.sv | 65 ++++++
 rtl/fpgasynth_key_ctrl.sv | 73 +++++++
 tb/tb_fpgasynth_key_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpgasynth_key_pkg.sv
// Shared constants and types for the front-panel pushbutton controller.
package fpgasynth_key_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RAW  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // 10 ms at 50 MHz
    localparam int DEB_CYCLES_DEFAULT = 500000;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } deb_state_t;

endpackage

// File: rtl/fpgasynth_key_debounce.sv
// One key: 2-flop synchroniser plus a counting debouncer. press_pulse is high
// in the cycle whose clock edge moves the stable level from 1 to 0.
module fpgasynth_key_debounce
    import fpgasynth_key_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_key,
    output logic sync,
    output logic stable,
    output logic press_pulse
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          meta;
    deb_state_t    state;
    logic [CW-1:0] count;
    logic          accept;

    // The level change is accepted on the edge where the counter has run out.
    assign accept      = (state == ST_COUNT) && (sync != stable) && (count == LAST);
    assign press_pulse = accept && !sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta   <= 1'b1;
            sync   <= 1'b1;
            stable <= 1'b1;
            count  <= '0;
            state  <= ST_STABLE;
        end else begin
            meta <= in_key;
            sync <= meta;
            case (state)
                ST_STABLE: begin
                    if (sync != stable) begin
                        state <= ST_COUNT;
                        count <= CW'(1);
                    end
                end
                ST_COUNT: begin
                    if (sync == stable) begin
                        state <= ST_STABLE;
                        count <= '0;
                    end else if (count == LAST) begin
                        stable <= sync;
                        state  <= ST_STABLE;
                        count  <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= ST_STABLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fpgasynth_key_ctrl.sv
// Avalon-MM pushbutton controller: per-key debounce, sticky press events,
// maskable level interrupt and a registered read mux.
module fpgasynth_key_ctrl
    import fpgasynth_key_pkg::*;
#(
    parameter int NKEYS      = 2,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [NKEYS-1:0] in_port,
    output logic             irq
);

    // Registers are kept 32 bits wide; bits at or above NKEYS are tied to 0.
    localparam logic [31:0] KEY_BITS = 32'((64'(1) << NKEYS) - 64'(1));

    logic [NKEYS-1:0] key_sync;
    logic [NKEYS-1:0] key_stable;
    logic [NKEYS-1:0] key_press;
    logic [31:0]      mask_q;
    logic [31:0]      edge_q;
    logic [31:0]      edge_clr;
    logic [31:0]      rd_mux;

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        fpgasynth_key_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_debounce (
            .clk        (clk),
            .reset_n    (reset_n),
            .in_key     (in_port[i]),
            .sync       (key_sync[i]),
            .stable     (key_stable[i]),
            .press_pulse(key_press[i])
        );
    end

    assign edge_clr = (write && address == ADDR_EDGE) ? writedata : 32'h0;

    always_comb begin
        rd_mux = 32'h0;
        case (address)
            ADDR_DATA: rd_mux = 32'(key_stable);
            ADDR_RAW:  rd_mux = 32'(key_sync);
            ADDR_MASK: rd_mux = mask_q;
            ADDR_EDGE: rd_mux = edge_q;
            default:   rd_mux = 32'h0;
        endcase
    end

    // A press arriving in the same cycle as a clear keeps its bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q   <= 32'h0;
            edge_q   <= 32'h0;
            irq      <= 1'b0;
            readdata <= 32'h0;
        end else begin
            if (write && address == ADDR_MASK) begin
                mask_q <= writedata & KEY_BITS;
            end
            edge_q   <= ((edge_q & ~edge_clr) | 32'(key_press)) & KEY_BITS;
            irq      <= |(edge_q & mask_q);
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_fpgasynth_key_ctrl.sv
// Directed bench for fpgasynth_key_ctrl with a short debounce window.
module tb_fpgasynth_key_ctrl;

    localparam int NKEYS = 2;
    localparam int DEB   = 4;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  in_port;
    logic        irq;

    int n_cmp;
    int n_fail;

    fpgasynth_key_ctrl #(
        .NKEYS     (NKEYS),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .address  (address),
        .write    (write),
        .writedata(writedata),
        .readdata (readdata),
        .in_port  (in_port),
        .irq      (irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [12];

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick(1);
        write     = 1'b0;
        writedata = 32'h0;
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        tick(1);
        check(name, readdata, exp);
    endtask

    initial begin
        logic seen_low;
        n_cmp     = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        address   = 2'd0;
        write     = 1'b0;
        writedata = 32'h0;
        in_port   = 2'b11;

        // register map walk with keys released; read data lags the address by one edge
        vecs[0]  = '{2'd0, 1'b0, 32'h0,        32'h3, 1'b0};
        vecs[1]  = '{2'd1, 1'b0, 32'h0,        32'h3, 1'b0};
        vecs[2]  = '{2'd2, 1'b0, 32'h0,        32'h0, 1'b0};
        vecs[3]  = '{2'd3, 1'b0, 32'h0,        32'h0, 1'b0};
        vecs[4]  = '{2'd2, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b0};
        vecs[5]  = '{2'd2, 1'b0, 32'h0,        32'h3, 1'b0};
        vecs[6]  = '{2'd0, 1'b1, 32'h0,        32'h3, 1'b0};
        vecs[7]  = '{2'd1, 1'b1, 32'h0,        32'h3, 1'b0};
        vecs[8]  = '{2'd2, 1'b1, 32'h1,        32'h3, 1'b0};
        vecs[9]  = '{2'd2, 1'b0, 32'h0,        32'h1, 1'b0};
        vecs[10] = '{2'd3, 1'b1, 32'hF,        32'h0, 1'b0};
        vecs[11] = '{2'd3, 1'b0, 32'h0,        32'h0, 1'b0};

        tick(2);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            address   = vecs[i].addr;
            write     = vecs[i].wr;
            writedata = vecs[i].wdata;
            tick(1);
            write     = 1'b0;
            writedata = 32'h0;
            check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
        end

        // key0 press with MASK=1: stable/EDGE at edge k+5, irq at k+6
        address = 2'd0;
        in_port = 2'b10;
        for (int c = 1; c <= 7; c++) begin
            tick(1);
            if (c == 6) begin
                check("press_irq_k5", {31'h0, irq}, 32'h0);
                check("press_data_k5", readdata, 32'h3);
            end
            if (c == 7) begin
                check("press_irq_k6", {31'h0, irq}, 32'h1);
                check("press_data_k6", readdata, 32'h2);
            end
        end
        rd_check("press_edge", 2'd3, 32'h1);
        rd_check("press_raw", 2'd1, 32'h2);

        // release sets no event
        in_port = 2'b11;
        tick(8);
        rd_check("release_data", 2'd0, 32'h3);
        rd_check("release_edge", 2'd3, 32'h1);

        // lone clear: irq drops one edge after the write
        wr(2'd3, 32'h1);
        check("clr_irq_j", {31'h0, irq}, 32'h1);
        tick(1);
        check("clr_irq_j1", {31'h0, irq}, 32'h0);
        rd_check("clr_edge", 2'd3, 32'h0);

        // key1 bounce of 3 cycles is rejected but visible on RAW
        address  = 2'd1;
        seen_low = 1'b0;
        in_port  = 2'b01;
        for (int c = 1; c <= 9; c++) begin
            tick(1);
            if (c == 3) in_port = 2'b11;
            if (readdata == 32'h1) seen_low = 1'b1;
        end
        check("bounce_raw_seen", {31'h0, seen_low}, 32'h1);
        rd_check("bounce_data", 2'd0, 32'h3);
        rd_check("bounce_edge", 2'd3, 32'h0);
        check("bounce_irq", {31'h0, irq}, 32'h0);

        // press key0, release, then a new press lands on a clear of the same bit
        in_port = 2'b10;
        tick(8);
        in_port = 2'b11;
        tick(8);
        rd_check("pre_setclr_edge", 2'd3, 32'h1);
        in_port = 2'b10;
        tick(5);
        wr(2'd3, 32'h1);
        check("setclr_irq", {31'h0, irq}, 32'h1);
        rd_check("setclr_edge", 2'd3, 32'h1);
        check("setclr_irq_after", {31'h0, irq}, 32'h1);
        wr(2'd3, 32'h1);
        tick(1);
        check("late_clr_irq", {31'h0, irq}, 32'h0);
        rd_check("late_clr_edge", 2'd3, 32'h0);
        in_port = 2'b11;
        tick(8);

        // masked event, then unmask
        wr(2'd2, 32'h0);
        in_port = 2'b01;
        tick(8);
        rd_check("masked_edge", 2'd3, 32'h2);
        check("masked_irq", {31'h0, irq}, 32'h0);
        wr(2'd2, 32'h3);
        check("unmask_irq_j", {31'h0, irq}, 32'h0);
        tick(1);
        check("unmask_irq_j1", {31'h0, irq}, 32'h1);
        in_port = 2'b11;
        tick(8);
        wr(2'd3, 32'h3);
        tick(1);

        // reset while key0's counter sits at 2
        address = 2'd0;
        in_port = 2'b10;
        tick(4);
        reset_n = 1'b0;
        tick(1);
        check("midrst_readdata", readdata, 32'h0);
        check("midrst_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick(1);
            if (c == 1) begin
                check("postrst_data", readdata, 32'h3);
                address = 2'd3;
            end
            if (c == 6) check("postrst_edge_k5", readdata, 32'h0);
            if (c == 7) check("postrst_edge_k6", readdata, 32'h1);
        end
        rd_check("postrst_mask", 2'd2, 32'h0);
        check("postrst_irq", {31'h0, irq}, 32'h0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
